// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Latency: request granted in cycle N returns its result from the response slot in cycle N+1.
// Backpressure: while the slot owner holds rsp_ready low, every req_ready stays low.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_*/o_req_ready     per-requester operation request (slice k of each packed bus)
//   o_rsp_*/i_rsp_ready     one-entry response slot, o_rsp_valid one-hot on the owner
//   o_alu_*/i_alu_*         drive to and result from the shared combinational ALU
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*4-1:0]    i_req_opcode,
  input  logic [NREQ*32-1:0]   i_req_wordA,
  input  logic [NREQ*32-1:0]   i_req_wordB,
  input  logic [NREQ*5-1:0]    i_req_shamt,
  output logic [NREQ-1:0]      o_rsp_valid,
  input  logic [NREQ-1:0]      i_rsp_ready,
  output logic [31:0]          o_rsp_result,
  output logic                 o_rsp_equal,
  output logic                 o_rsp_notequal,
  output logic [3:0]           o_alu_opcode,
  output logic [31:0]          o_alu_wordA,
  output logic [31:0]          o_alu_wordB,
  output logic [4:0]           o_alu_shamt,
  input  logic [31:0]          i_alu_output,
  input  logic                 i_alu_flag_equal,
  input  logic                 i_alu_flag_notequal
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic          slot_full;
  logic [PW-1:0] slot_owner;
  logic [31:0]   slot_result;
  logic          slot_eq;
  logic          slot_ne;

  logic          slot_free;
  logic          gnt_any;
  logic [PW-1:0] gidx;
  logic [PW-1:0] cand;
  int            sum;

  // The slot may be drained and refilled in the same cycle, so it counts as
  // free when the owner is taking the current response.
  always_comb begin
    slot_free = ~slot_full | i_rsp_ready[slot_owner];
    gnt_any   = 1'b0;
    gidx      = '0;
    cand      = '0;
    sum       = 0;
    // Search from ptr upwards, wrapping; first valid requester wins.
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = PW'(sum);
      if (slot_free && !gnt_any && i_req_valid[cand]) begin
        gnt_any = 1'b1;
        gidx    = cand;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (gnt_any) o_req_ready[gidx] = 1'b1;
  end

  // Idle cycles present an all-zero operation to the ALU.
  always_comb begin
    o_alu_opcode = '0;
    o_alu_wordA  = '0;
    o_alu_wordB  = '0;
    o_alu_shamt  = '0;
    if (gnt_any) begin
      o_alu_opcode = i_req_opcode[gidx*4 +: 4];
      o_alu_wordA  = i_req_wordA[gidx*32 +: 32];
      o_alu_wordB  = i_req_wordB[gidx*32 +: 32];
      o_alu_shamt  = i_req_shamt[gidx*5 +: 5];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr         <= '0;
      slot_full   <= 1'b0;
      slot_owner  <= '0;
      slot_result <= '0;
      slot_eq     <= 1'b0;
      slot_ne     <= 1'b0;
    end else if (gnt_any) begin
      slot_result <= i_alu_output;
      slot_eq     <= i_alu_flag_equal;
      slot_ne     <= i_alu_flag_notequal;
      slot_owner  <= gidx;
      slot_full   <= 1'b1;
      ptr         <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end else if (slot_full && i_rsp_ready[slot_owner]) begin
      // Drain only; data registers keep the last response.
      slot_full <= 1'b0;
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_rsp_valid[k] = slot_full && (slot_owner == PW'(k));
    end
  end

  assign o_rsp_result   = slot_result;
  assign o_rsp_equal    = slot_eq;
  assign o_rsp_notequal = slot_ne;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU instance between NREQ requesters (e.g. execute stage, address-generation unit, branch unit) with valid/ready handshakes. Round-robin grant: one operation issued per cycle, ALU result and flags captured in a one-entry response register returned to the owning requester. Sits between the issue logic and the ALU; the ALU itself is unchanged and purely combinational.

## Interface
- NREQ, 2, number of requesters (2..8); requester k uses slice k of every packed bus
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  NREQ  request pending, per requester
- o_req_ready  out  NREQ  one-hot grant; request k accepted in cycles where valid[k] & ready[k]
- i_req_opcode  in  NREQ*4  ALU opcode (ALU encoding 0x0 ADD .. 0xF SRAV)
- i_req_wordA  in  NREQ*32  operand A
- i_req_wordB  in  NREQ*32  operand B
- i_req_shamt  in  NREQ*5  shift amount / bit index
- o_rsp_valid  out  NREQ  one-hot, response slot full and owned by requester k
- i_rsp_ready  in  NREQ  requester k accepts response
- o_rsp_result  out  32  captured ALU output
- o_rsp_equal  out  1  captured ALU equal flag
- o_rsp_notequal  out  1  captured ALU not-equal flag
- o_alu_opcode  out  4  to ALU
- o_alu_wordA  out  32  to ALU
- o_alu_wordB  out  32  to ALU
- o_alu_shamt  out  5  to ALU
- i_alu_output  in  32  from ALU
- i_alu_flag_equal  in  1  from ALU
- i_alu_flag_notequal  in  1  from ALU

## Operation
- State: priority pointer ptr (0..NREQ-1), slot_full, slot_owner (index), slot_result[31:0], slot_eq, slot_ne.
- slot_free = ~slot_full | i_rsp_ready[slot_owner] (drain and refill same cycle allowed).
- Grant: if slot_free, first k with i_req_valid[k] searching ptr, ptr+1, ..., wrapping mod NREQ. At most one grant bit set. No grant when slot not free or no valid.
- o_req_ready = grant vector (combinational from i_req_valid, ptr, slot state). Requesters must not make valid depend on ready; payload held stable while valid & ~ready.
- ALU drive: payload of granted requester; no grant -> opcode 0x0, wordA 0, wordB 0, shamt 0.
- On grant to k: slot_result <= i_alu_output, slot_eq/ne <= ALU flags, slot_owner <= k, slot_full <= 1, ptr <= (k+1) mod NREQ.
- Drain without grant: slot_full <= 0; data registers hold last value.
- No grant: ptr unchanged.
- o_rsp_valid[k] = slot_full & (slot_owner == k). o_rsp_* driven from slot registers.
- i_rsp_ready of non-owner ignored. Response never dropped or overwritten before owner's ready.
- Fairness: a continuously-valid requester waits at most NREQ-1 grants to others.

## Timing
- Reset (async assert, sync-to-clock deassert by surrounding logic): ptr=0, slot_full=0, slot_owner=0, slot_result=0, slot_eq=0, slot_ne=0; o_rsp_valid=0, o_rsp_result=0, flags 0; o_req_ready=0 only if no valids (combinational).
- Reset mid-operation: in-flight response discarded, no ready/valid pulses afterward until new grant.
- Latency: request granted in cycle N -> o_rsp_valid set, result visible in cycle N+1.
- Throughput: one op per cycle when owner's i_rsp_ready held high.
- Backpressure: owner's i_rsp_ready low -> all o_req_ready low until drained.
- Flags: o_rsp_equal/notequal are mutually exclusive whenever slot_full.

## Test plan
- Single op: NREQ=2, req0 ADD A=5 B=7 at cycle 0 -> ready[0]=1 cycle 0; cycle 1 rsp_valid=01, result=12, equal=0, notequal=1.
- Round-robin: both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1 from reset; ptr after each grant = other requester.
- Backpressure: req1 SUB A=3 B=3 granted, rsp_ready[1]=0 for 3 cycles with req0 valid -> rsp_valid=10 held, result=0, equal=1, ready all 0; on rsp_ready[1]=1 req0 granted same cycle, its response next cycle.
- Wrong-owner ready: slot owned by 0, rsp_ready=10 -> slot held, no new grant.
- ALU passthrough: req0 SRAV A=0x80000000 B=4 -> o_alu_* equal payload in grant cycle; result 0xF8000000. Idle cycle -> o_alu_* all zero.
- Reset mid-op: assert i_rst_n=0 while rsp_valid=01 -> rsp_valid=0, result=0 immediately (async); after release first grant goes to lowest valid index starting at 0.
